// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction constants, fetch FSM states and the
// fetch buffer entry layout.
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR  = 16'h0800;
    localparam logic [15:0] HALT_INSTR = 16'h0000;
    localparam logic [15:0] PC_STEP    = 16'd2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] inc;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{instr: NOP_INSTR, inc: 16'h0000};

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {instr, inc} pairs; clear wins over push/pop, and a
// push together with a pop is accepted even when full.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can leave a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 2'd1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop updates from the same pre-edge values.
        if (rst) begin
            // NOTE: entries are reset too, so the IF/ID outputs read NOP/0 out of reset.
            mem_q[0] <= RESET_ENTRY;
            mem_q[1] <= RESET_ENTRY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding IF/ID: PC, single-outstanding imem requests,
// redirect squash and HALT stop. Define FETCH_BYPASS_EN to forward a response
// straight to IF/ID when the buffer is empty.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] instruction,
    output logic [15:0] increment,
    output logic        fetch_valid,
    output logic        flush,
    output logic        halted
);

    localparam logic [1:0] BUF_LIMIT = 2'(BUF_DEPTH);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  req_addr_q, req_addr_d;
    logic         outstanding_q, outstanding_d;
    logic         stale_q, stale_d;

    fetch_entry_t resp_entry, buf_head;
    logic [1:0]   buf_count, occ_next;
    logic         buf_push, buf_pop;
    logic         resp_arrive, resp_accept, is_halt, bypass, deliver, issue, active;

    fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .clear (redirect),
        .wdata (resp_entry),
        .rdata (buf_head),
        .count (buf_count)
    );

    always_comb begin
        resp_arrive = imem_valid && outstanding_q;
        resp_accept = resp_arrive && !stale_q && !redirect;
        is_halt     = resp_accept && (imem_rdata == HALT_INSTR);
        resp_entry  = '{instr: imem_rdata, inc: req_addr_q + PC_STEP};
`ifdef FETCH_BYPASS_EN
        bypass      = resp_accept && (buf_count == 2'd0);
`else
        bypass      = 1'b0;
`endif
        fetch_valid = (buf_count != 2'd0) || bypass;
        instruction = bypass ? imem_rdata : buf_head.instr;
        increment   = bypass ? resp_entry.inc : buf_head.inc;
        deliver     = fetch_valid && !stall && !redirect;
        buf_pop     = deliver && !bypass;
        // A bypassed word that is consumed at once never enters the buffer.
        buf_push    = resp_accept && !(bypass && !stall);

        occ_next = buf_count;
        if (buf_push && !buf_pop) begin
            occ_next = buf_count + 2'd1;
        end else if (!buf_push && buf_pop) begin
            occ_next = buf_count - 2'd1;
        end

        active = (state_q == RUN) || (state_q == WAIT);
        issue  = active && (!outstanding_q || resp_arrive) && (occ_next < BUF_LIMIT)
                 && !is_halt && !redirect;
    end

    always_comb begin
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;
        state_d       = state_q;

        if (issue) begin
            pc_d          = pc_q + PC_STEP;
            req_addr_d    = pc_q;
            outstanding_d = 1'b1;
        end else if (resp_arrive) begin
            outstanding_d = 1'b0;
        end

        if (redirect) begin
            stale_d = outstanding_q && !resp_arrive;
        end else if (resp_arrive) begin
            stale_d = 1'b0;
        end

        case (state_q)
            BOOT:      state_d = RUN;
            RUN, WAIT: state_d = is_halt ? HALT : (issue ? RUN : WAIT);
            default:   state_d = state_q;
        endcase

        if (redirect) begin
            pc_d    = redirect_pc & 16'hFFFE;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign flush     = redirect;
    assign halted    = (state_q == HALT);

endmodule
